// File: rtl/usb_tx_pkt_pkg.sv
// Shared USB definitions: PID codes, PID class mask,
// CRC16 constants and the packet formatter state encoding.
package usb_defs;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    localparam logic [1:0] PID_CLASS_DATA = 2'b11;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } tx_state_e;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid[1:0] == PID_CLASS_DATA;
    endfunction

endpackage

// File: rtl/usb_crc16_ser.sv
// Bit-serial CRC-16/USB register (reflected polynomial),
// fed one payload bit per enable in transmit order.
module usb_crc16_ser
    import usb_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[0] ^ bit_in;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx_pkt.sv
// USB packet formatter: serialises PID, payload and CRC16
// as raw LSB-first bits, paced by the line driver's ll_ack.
module usb_tx_pkt
    import usb_defs::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pkt_start,
    input  logic [3:0]       pkt_pid,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [7:0]       pkt_data,
    output logic             pkt_data_ack,
    output logic             pkt_done,
    output logic             pkt_busy,
    output logic             ll_start,
    output logic             ll_bit,
    output logic             ll_last,
    input  logic             ll_ack
);

    tx_state_e        state_q, state_d;
    logic             data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             ll_start_q, ll_start_d;

    logic             crc_init;
    logic             crc_en;
    logic [15:0]      crc_val;
    logic             byte_end;

    assign byte_end = bit_cnt_q == 4'd7;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        ll_start_d   = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        pkt_data_ack = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pkt_start) begin
                    data_d     = is_data_pid(pkt_pid);
                    len_d      = pkt_len;
                    shift_d    = {~pkt_pid, pkt_pid};
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = '0;
                    crc_init   = 1'b1;
                    ll_start_d = 1'b1;
                    state_d    = ST_PID;
                end
            end
            ST_PID: begin
                if (ll_ack) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (byte_end) begin
                        bit_cnt_d = 4'd0;
                        if (!data_q) begin
                            state_d = ST_DONE;
                        end else if (len_q != '0) begin
                            shift_d      = pkt_data;
                            pkt_data_ack = 1'b1;
                            byte_cnt_d   = len_q - LEN_W'(1);
                            state_d      = ST_DATA;
                        end else begin
                            state_d = ST_CRC;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (ll_ack) begin
                    crc_en    = 1'b1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (byte_end) begin
                        bit_cnt_d = 4'd0;
                        if (byte_cnt_q != '0) begin
                            shift_d      = pkt_data;
                            pkt_data_ack = 1'b1;
                            byte_cnt_d   = byte_cnt_q - LEN_W'(1);
                        end else begin
                            state_d = ST_CRC;
                        end
                    end
                end
            end
            ST_CRC: begin
                // CRC register is frozen here; bits are read out by index
                if (ll_ack) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= 1'b0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ll_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ll_start_q <= ll_start_d;
        end
    end

    usb_crc16_ser u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (crc_init),
        .en      (crc_en),
        .bit_in  (shift_q[0]),
        .crc_out (crc_val)
    );

    always_comb begin
        ll_bit = 1'b0;
        unique case (state_q)
            ST_PID, ST_DATA: ll_bit = shift_q[0];
            ST_CRC:          ll_bit = ~crc_val[bit_cnt_q];
            default:         ll_bit = 1'b0;
        endcase
    end

    assign ll_last  = ((state_q == ST_PID) && !data_q && byte_end) ||
                      ((state_q == ST_CRC) && (bit_cnt_q == 4'd15));
    assign ll_start = ll_start_q;
    assign pkt_busy = (state_q == ST_PID) || (state_q == ST_DATA) ||
                      (state_q == ST_CRC);
    assign pkt_done = state_q == ST_DONE;

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Randomised bench for usb_tx_pkt against a byte-level
// packet/CRC reference model.
module tb_usb_tx_pkt;

    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pkt_start = 1'b0;
    logic [3:0]       pkt_pid = '0;
    logic [LEN_W-1:0] pkt_len = '0;
    logic [7:0]       pkt_data = '0;
    logic             ll_ack = 1'b0;
    logic             pkt_data_ack;
    logic             pkt_done;
    logic             pkt_busy;
    logic             ll_start;
    logic             ll_bit;
    logic             ll_last;

    int checks = 0;
    int failures = 0;

    logic [7:0] payload [0:1023];
    bit exp_q [$];
    bit obs [$];
    bit saved [$];

    always #10 clk = ~clk;

    usb_tx_pkt #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_start    (pkt_start),
        .pkt_pid      (pkt_pid),
        .pkt_len      (pkt_len),
        .pkt_data     (pkt_data),
        .pkt_data_ack (pkt_data_ack),
        .pkt_done     (pkt_done),
        .pkt_busy     (pkt_busy),
        .ll_start     (ll_start),
        .ll_bit       (ll_bit),
        .ll_last      (ll_last),
        .ll_ack       (ll_ack)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {8'h00, payload[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic void build_exp(input logic [3:0] pid, input int len);
        logic [7:0]  bytes [$];
        logic [7:0]  bv;
        logic [15:0] c;
        exp_q.delete();
        bytes.push_back({~pid, pid});
        if (pid[1:0] == 2'b11) begin
            for (int i = 0; i < len; i++) bytes.push_back(payload[i]);
            c = ~ref_crc(len);
            bytes.push_back(c[7:0]);
            bytes.push_back(c[15:8]);
        end
        foreach (bytes[i]) begin
            bv = bytes[i];
            for (int j = 0; j < 8; j++) exp_q.push_back(bv[j]);
        end
    endfunction

    task automatic send(input logic [3:0] pid, input int len,
                        input int gmin, input int gmax,
                        input int poke_at, input int abort_at);
        int n, idx, acks, unstable, lastbad, startbad;
        int busybad, donebad, gap, mism;
        bit b, l, adv;
        n = 0; idx = 0; acks = 0; unstable = 0; lastbad = 0;
        startbad = 0; busybad = 0; donebad = 0; mism = 0;
        build_exp(pid, len);
        n = exp_q.size();
        obs.delete();
        @(negedge clk);
        pkt_pid   = pid;
        pkt_len   = len[LEN_W-1:0];
        pkt_data  = (len > 0) ? payload[0] : 8'($urandom);
        pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        check("ll_start", ll_start, 1);
        check("busy_start", pkt_busy, 1);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", {ll_start, ll_bit, ll_last, pkt_busy,
                      pkt_done, pkt_data_ack}, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (pkt_done) donebad++;
                end
                check("abort_no_done", donebad, 0);
                rst_n = 1'b1;
                return;
            end
            b = ll_bit;
            l = ll_last;
            obs.push_back(b);
            if (l != (k == n - 1)) lastbad++;
            if (!pkt_busy) busybad++;
            if (pkt_done) donebad++;
            if (k > 0 && ll_start) startbad++;
            gap = (gmax == 0) ? 0 : int'($urandom_range(gmax, gmin)) - 1;
            repeat (gap) begin
                @(negedge clk);
                if (ll_bit !== b || ll_last !== l) unstable++;
                if (ll_start) startbad++;
            end
            if (k == poke_at) begin
                pkt_start = 1'b1;
                pkt_pid   = 4'h2;
                pkt_len   = '0;
            end
            ll_ack = 1'b1;
            #1;
            adv = pkt_data_ack;
            if (adv) acks++;
            @(negedge clk);
            ll_ack    = 1'b0;
            pkt_start = 1'b0;
            pkt_pid   = pid;
            pkt_len   = len[LEN_W-1:0];
            if (adv) begin
                idx++;
                pkt_data = (idx < len) ? payload[idx] : 8'($urandom);
            end
        end
        check("done_pulse", pkt_done, 1);
        check("busy_at_done", pkt_busy, 0);
        @(negedge clk);
        check("done_once", {pkt_done, pkt_busy}, 0);
        foreach (obs[i]) if (obs[i] !== exp_q[i]) mism++;
        check("stream_bits", mism, 0);
        check("last_pos", lastbad, 0);
        check("stable", unstable, 0);
        check("start_once", startbad, 0);
        check("busy_hold", busybad, 0);
        check("early_done", donebad, 0);
        check("data_acks", acks, (pid[1:0] == 2'b11) ? len : 0);
    endtask

    function automatic logic [15:0] obs_word(input int base, input int nb);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[i] = obs[base + i];
        return v;
    endfunction

    initial begin
        int mism;
        logic [3:0] rp;
        int rl;
        repeat (3) @(negedge clk);
        check("reset_outs", {ll_start, ll_bit, ll_last, pkt_busy,
              pkt_done, pkt_data_ack}, 0);
        rst_n = 1'b1;

        repeat (3) begin
            @(negedge clk);
            ll_ack = 1'b1;
        end
        @(negedge clk);
        ll_ack = 1'b0;
        check("idle_ack", {ll_start, ll_bit, ll_last, pkt_busy, pkt_done}, 0);

        send(4'h2, 0, 0, 0, -1, -1);
        check("ack_len", obs.size(), 8);
        check("ack_byte", obs_word(0, 8), 16'h00D2);

        send(4'hB, 0, 1, 2, -1, -1);
        check("zlp_len", obs.size(), 24);
        check("zlp_pid", obs_word(0, 8), 16'h004B);
        check("zlp_crc", obs_word(8, 16), 16'h0000);

        for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
        send(4'h3, 9, 0, 0, -1, -1);
        check("d0_len", obs.size(), 96);
        check("d0_crc", obs_word(80, 16), 16'hB4C8);

        for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
        send(4'h3, 4, 0, 0, -1, -1);
        saved = obs;
        send(4'h3, 4, 3, 12, -1, -1);
        mism = (saved.size() == obs.size()) ? 0 : 1;
        foreach (obs[i]) if (i < saved.size() && obs[i] !== saved[i]) mism++;
        check("gap_same", mism, 0);

        send(4'hB, 4, 1, 3, 20, -1);
        send(4'h3, 4, 0, 0, -1, 20);
        send(4'h2, 0, 0, 0, -1, -1);
        check("post_abort_ack", obs_word(0, 8), 16'h00D2);

        for (int r = 0; r < 6; r++) begin
            rp = 4'($urandom);
            rl = int'($urandom_range(20, 0));
            for (int i = 0; i < rl; i++) payload[i] = 8'($urandom);
            send(rp, rl, 1, 3, -1, -1);
        end

        for (int i = 0; i < 1023; i++) payload[i] = 8'(i);
        send(4'h3, 1023, 0, 0, -1, -1);
        check("big_len", obs.size(), 8 * 1026);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_pkt.md
Name: usb_tx_pkt

Overview:
- Packet formatter directly downstream of the transaction micro-sequencer; consumes its txpkt_* handshake (start/pid/len/data/data_ack/done).
- Serialises PID byte, optional payload and CRC16 into a bit stream, LSB first, towards the low-level TX line driver.
- The line driver owns SYNC, EOP, bit stuffing and NRZI; this block only produces raw packet bits, paced by ll_ack.

Parameters:
LEN_W, 10, width of pkt_len; maximum payload is 2^LEN_W-1 bytes.

Ports:
clk  input  1  system clock, 48 MHz domain
rst_n  input  1  asynchronous active-low reset
pkt_start  input  1  one-cycle request to send a packet; pkt_pid/pkt_len are sampled this cycle
pkt_pid  input  4  PID; the transmitted byte is {~pid, pid}
pkt_len  input  LEN_W  payload byte count, used only for DATA PIDs
pkt_data  input  8  current payload byte; valid 1 cycle after pkt_start or after any pkt_data_ack
pkt_data_ack  output  1  one-cycle pulse: pkt_data was consumed, upstream advances to the next byte
pkt_done  output  1  one-cycle pulse after the final bit is acked
pkt_busy  output  1  high from the cycle after accepted pkt_start until pkt_done
ll_start  output  1  one-cycle pulse: packet begins, first bit valid
ll_bit  output  1  current bit
ll_last  output  1  high while ll_bit is the final bit of the packet
ll_ack  input  1  one-cycle pulse: line driver consumed ll_bit

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters and CRC cleared.
- FSM states: IDLE, PID, DATA, CRC, DONE.
- IDLE: pkt_start=1 -> latch pid and len, load shifter with {~pid,pid}, bit_cnt=0, go to PID. ll_start pulses the next cycle (latency 1) with ll_bit = pid[0].
- Bit advance happens only on ll_ack. ll_bit and ll_last update in the cycle after ll_ack and are otherwise held stable for any ack gap.
- Packet class:
  - pid[1:0]==2'b11 is DATA: PID, then len payload bytes, then 16 CRC bits.
  - Any other pid is PID only: 8 bits, ll_last on bit 7.
- PID, 8th ack:
  - DATA with len>0: load shifter from pkt_data, pulse pkt_data_ack the same cycle, byte_cnt=len-1, go to DATA.
  - DATA with len=0: go to CRC.
  - Otherwise: go to DONE.
- DATA: each ack shifts the shifter and feeds ll_bit into the CRC.
  - 8th ack with byte_cnt!=0: reload from pkt_data, pulse pkt_data_ack, decrement byte_cnt.
  - 8th ack with byte_cnt==0: go to CRC. No ack pulse is issued for a byte beyond len.
- CRC:
  - Algorithm: CRC-16/USB, polynomial 0x8005 reflected (0xA001), init 0xFFFF, bit-serial over payload bits in transmit order.
  - Transmitted value is the ones' complement, LSB first, 16 bits.
  - ll_last is high on the 16th CRC bit.
  - The CRC register freezes while in CRC state; it is not updated with its own bits.
- DONE: entered on the ack of the ll_last bit. pkt_done pulses 1 cycle later, then IDLE. pkt_busy deasserts together with the pkt_done pulse.
- pkt_start while not IDLE: ignored, no side effects.
- ll_ack while IDLE: ignored.
- pkt_len > 2^LEN_W-1 cannot occur (port width). byte_cnt never wraps.
- Zero-length DATA: CRC bytes are 0x00, 0x00.
- rst_n asserted mid-packet: immediate abort, no pkt_done. The first pkt_start after release behaves normally.
- pkt_data_ack is never asserted in the same cycle as pkt_start.

Decomposition:
- Shared package usb_defs: PID constants (PID_ACK, PID_NAK, PID_STALL, PID_DATA0/1), PID-class mask (DATA = 2'b11), CRC16 polynomial 0xA001, init 0xFFFF, and FSM state encoding.
- One sub-module, usb_crc16_ser: serial CRC register with init, enable, bit_in and crc_out.

Test Plan:
- ACK, pkt_pid=0x2 -> byte 0xD2, bits 0,1,0,0,1,0,1,1; ll_last on bit 8; pkt_done 1 cycle after 8th ack; no pkt_data_ack.
- DATA1 ZLP, pid=0xB, len=0 -> bytes 0x4B, 0x00, 0x00 (24 bits); ll_last on bit 24; no pkt_data_ack.
- DATA0, pid=0x3, len=9, payload "123456789" -> 9 pkt_data_ack pulses, CRC bytes 0xC8 then 0xB4, 96 bits total.
- Random ll_ack gaps of 3..12 cycles with len=4 -> ll_bit/ll_last stable between acks; bit stream identical to the zero-gap run.
- pkt_start pulsed mid-DATA -> ignored, stream unchanged. rst_n low at bit 20 of a DATA packet -> outputs 0 asynchronously, no pkt_done. The next ACK packet is correct.
- len=1023 with an incrementing byte pattern -> exactly 1023 acks, CRC matches the reference model, pkt_busy high throughout.
